// File: rtl/rq_addsub_pipe_if.sv
// Stream interface for rq_addsub_pipe: input beat channel and output beat channel.
// The slave modport is the arithmetic block; the master modport is the beat source/sink.
interface rq_addsub_pipe_if #(
    parameter int NUM_BIT = 13,
    parameter int LANES   = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [1:0]                 in_op;
    logic [LANES*NUM_BIT-1:0]   in_x1;
    logic [LANES*NUM_BIT-1:0]   in_x2;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*NUM_BIT-1:0]   out_sum;
    logic [LANES-1:0]           out_wrap;
    logic                       out_last;

    modport master (
        output in_valid, in_op, in_x1, in_x2, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_wrap, out_last
    );

    modport slave (
        input  in_valid, in_op, in_x1, in_x2, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_wrap, out_last
    );
endinterface

// File: rtl/rq_addsub_pipe.sv
// Pipelined multi-lane Rq (mod 2^NUM_BIT) add/sub/accumulate/load unit built on a
// Sklansky parallel-prefix adder, with a valid/ready stream on both sides.
module rq_addsub_pipe #(
    parameter int NUM_BIT = 13,
    parameter int LANES   = 4,
    parameter int PIPE    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    rq_addsub_pipe_if.slave   bus
);
    localparam int W   = LANES * NUM_BIT;
    localparam int LOG = $clog2(NUM_BIT);

    logic             advance;
    logic             accept;
    logic [W-1:0]     res_sum;
    logic [LANES-1:0] res_wrap;
    logic [NUM_BIT-1:0] acc [LANES];

    logic             st_valid [PIPE];
    logic [W-1:0]     st_sum   [PIPE];
    logic [LANES-1:0] st_wrap  [PIPE];
    logic             st_last  [PIPE];

    assign advance      = ~bus.out_valid | bus.out_ready;
    assign accept       = bus.in_valid & advance;
    assign bus.in_ready = advance;

    // Returns {carry_out, sum}; group g/p over [i:0] are built in LOG Sklansky levels,
    // then the carry-in is folded in as a final generate term.
    function automatic logic [NUM_BIT:0] prefix_add(
        input logic [NUM_BIT-1:0] a,
        input logic [NUM_BIT-1:0] b,
        input logic               cin
    );
        logic [NUM_BIT-1:0] hs;
        logic [NUM_BIT-1:0] g;
        logic [NUM_BIT-1:0] p;
        logic [NUM_BIT-1:0] gn;
        logic [NUM_BIT-1:0] pn;
        logic [NUM_BIT-1:0] c;
        logic               cout;
        int                 j;
        hs = a ^ b;
        g  = a & b;
        p  = hs;
        for (int l = 0; l < LOG; l++) begin
            gn = g;
            pn = p;
            for (int i = 0; i < NUM_BIT; i++) begin
                if (((i >> l) & 1) == 1) begin
                    j     = ((i >> l) << l) - 1;
                    gn[i] = g[i] | (p[i] & g[j]);
                    pn[i] = p[i] & p[j];
                end
            end
            g = gn;
            p = pn;
        end
        c[0] = cin;
        for (int i = 1; i < NUM_BIT; i++) begin
            c[i] = g[i-1] | (p[i-1] & cin);
        end
        cout = g[NUM_BIT-1] | (p[NUM_BIT-1] & cin);
        return {cout, hs ^ c};
    endfunction

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [NUM_BIT-1:0] x1;
        logic [NUM_BIT-1:0] x2;
        logic [NUM_BIT-1:0] opa;
        logic [NUM_BIT-1:0] opb;
        logic               cin;
        logic [NUM_BIT:0]   r;

        assign x1 = bus.in_x1[k*NUM_BIT +: NUM_BIT];
        assign x2 = bus.in_x2[k*NUM_BIT +: NUM_BIT];

        // Subtraction reuses the same network as x1 + ~x2 + 1; load adds zero.
        always_comb begin
            opa = x1;
            opb = '0;
            cin = 1'b0;
            case (bus.in_op)
                2'b00: opb = x2;
                2'b01: begin
                    opb = ~x2;
                    cin = 1'b1;
                end
                2'b10: begin
                    opa = acc[k];
                    opb = x1;
                end
                default: opb = '0;
            endcase
        end

        assign r = prefix_add(opa, opb, cin);
        assign res_sum[k*NUM_BIT +: NUM_BIT] = r[NUM_BIT-1:0];
        // A borrow shows up as the absence of carry-out when subtracting.
        assign res_wrap[k] = (bus.in_op == 2'b01) ? ~r[NUM_BIT] :
                             (bus.in_op == 2'b11) ? 1'b0 : r[NUM_BIT];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                acc[k] <= '0;
            end
        end else if (accept && bus.in_op[1]) begin
            for (int k = 0; k < LANES; k++) begin
                acc[k] <= res_sum[k*NUM_BIT +: NUM_BIT];
            end
        end
    end

    // Stage 0 captures the finished result; later stages are plain retiming registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < PIPE; s++) begin
                st_valid[s] <= 1'b0;
                st_sum[s]   <= '0;
                st_wrap[s]  <= '0;
                st_last[s]  <= 1'b0;
            end
        end else if (advance) begin
            st_valid[0] <= accept;
            st_sum[0]   <= res_sum;
            st_wrap[0]  <= res_wrap;
            st_last[0]  <= bus.in_last;
            for (int s = 1; s < PIPE; s++) begin
                st_valid[s] <= st_valid[s-1];
                st_sum[s]   <= st_sum[s-1];
                st_wrap[s]  <= st_wrap[s-1];
                st_last[s]  <= st_last[s-1];
            end
        end
    end

    assign bus.out_valid = st_valid[PIPE-1];
    assign bus.out_sum   = st_sum[PIPE-1];
    assign bus.out_wrap  = st_wrap[PIPE-1];
    assign bus.out_last  = st_last[PIPE-1];
endmodule

// File: doc/rq_addsub_pipe.md
Name: rq_addsub_pipe

Overview:
- Parametrised, pipelined, multi-lane modular adder/subtractor for Rq coefficients (q = 2^NUM_BIT; default q = 8192) in the Encaps datapath.
- Successor to the fixed 13-bit combinational prefix adder. Adds configurable width, lane count and pipeline depth, an add/sub/accumulate mode per beat, a wrap flag, and a valid/ready stream handshake.

Parameters:
- NUM_BIT, 13, coefficient width; arithmetic is mod 2^NUM_BIT. Legal range 2..32.
- LANES, 4, independent coefficient lanes per beat.
- PIPE, 2, register stages from accept to output. Legal values 1..3.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_op  in  2  operation: 00 add, 01 sub, 10 accumulate, 11 load.
- in_x1  in  LANES*NUM_BIT  operand 1; lane k occupies bits [k*NUM_BIT +: NUM_BIT].
- in_x2  in  LANES*NUM_BIT  operand 2, same packing; ignored for ops 10 and 11.
- in_last  in  1  end-of-block marker, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_sum  out  LANES*NUM_BIT  results, same lane packing.
- out_wrap  out  LANES  per-lane modular wrap flag.
- out_last  out  1  delayed in_last.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all pipeline valid bits, out_valid, out_sum, out_wrap, out_last = 0;
  - all lane accumulators = 0;
  - in_ready is combinational, so it reads 1 while out_valid = 0.
  - Reset asserted mid-operation discards every in-flight beat; no partial output appears after release.
- Handshake:
  - accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - advance = ~out_valid | out_ready.
  - in_ready = advance.
  - The pipeline moves as a whole only when advance = 1; otherwise every stage holds, including out_sum, out_wrap and out_last.
  - out_* is stable while out_valid & ~out_ready.
  - No combinational path from in_valid to out_valid.
- Latency: a beat accepted in cycle t appears on out_* at the end of cycle t+PIPE-1, i.e. visible in cycle t+PIPE, provided advance stayed 1.
- Throughput: 1 beat/cycle when out_ready is held at 1.
- Bubbles (cycles with in_valid = 0) propagate as stages with valid = 0 and are never emitted.
- Per-lane arithmetic, with all results truncated to NUM_BIT bits:
  - op 00: sum = x1 + x2; wrap = carry-out of bit NUM_BIT-1.
  - op 01: sum = x1 - x2 (x1 + ~x2 + 1); wrap = 1 iff x1 < x2 (borrow).
  - op 10: sum = acc + x1; wrap = carry-out; acc <= sum on accept.
  - op 11: sum = x1; wrap = 0; acc <= x1 on accept.
- Accumulators:
  - Update only on accept; held on stall.
  - ops 00 and 01 leave acc unchanged.
  - Back-to-back op-10 beats see the previous beat's updated acc with no bubble; the accumulator update path is single-cycle.
- Adder structure:
  - Parallel-prefix, Sklansky-style g/p network of depth ceil(log2 NUM_BIT), generated from NUM_BIT.
  - Subtraction reuses the same network with an inverted operand and carry-in 1.
  - The full result is formed in the accept cycle and captured in stage 1.
  - Stages 2..PIPE are pure registers, available for retiming.
- out_last: carried with its beat through every stage; it does not alter the accumulators.

Test Plan:
- Add with wrap (NUM_BIT=13, lane0 8191 + 1, lane1 100 + 200, PIPE=2) -> out_sum lane0 = 0, lane1 = 300; out_wrap = 4'b0001; out_valid exactly 2 cycles after accept.
- Subtract (lane0 5 - 7, lane1 7 - 5) -> lane0 = 8190 with wrap 1; lane1 = 2 with wrap 0.
- Accumulate (op 11 load 0, then op 10 with x1 = 4000 three times back-to-back on lane0) -> outputs 0, 4000, 8000, 3808; out_wrap[0] sequence 0, 0, 0, 1.
- Backpressure (stream 6 add beats with out_ready toggling 1,0,0,1,0,1...) -> all 6 results emitted in order, none duplicated or lost; out_* stable during each stall; acc unchanged across stalls.
- Reset mid-stream (assert rst_n low with 2 beats in flight and acc = 1234) -> out_valid = 0 immediately, acc = 0; after release the first op-10 beat with x1 = 5 returns 5.
- in_last pass-through (4 beats with last on beat 4, PIPE = 3) -> out_last = 1 only on the 4th emitted beat.
